// File: rtl/proc_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// proc_control_unit_pkg
// Shared definitions for the simple-processor control sequencer: instruction
// opcodes, sequencer step encodings and instruction-register field positions.
// -----------------------------------------------------------------------------
package proc_control_unit_pkg;

    // Opcodes held in IR[8:6]; any opcode with the top bit set is reserved.
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // Sequencer steps, plain 2-bit binary. T0 is idle/fetch.
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_e;

    // Instruction register field positions: III XXX YYY.
    localparam int IR_OP_HI = 8;
    localparam int IR_OP_LO = 6;
    localparam int IR_X_HI  = 5;
    localparam int IR_X_LO  = 3;
    localparam int IR_Y_HI  = 2;
    localparam int IR_Y_LO  = 0;

    // True for the two opcodes that run through the ALU (T2/T3).
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/proc_control_unit_dec3to8.sv
// -----------------------------------------------------------------------------
// dec3to8
// 3-bit binary to 8-bit one-hot decoder with enable. Used to turn the X and Y
// register fields of the instruction into register-file select lines.
//   sel_i     3-bit register number
//   en_i      1 = drive the one-hot code, 0 = all zeros
//   onehot_o  bit n set when sel_i == n and en_i is high
// -----------------------------------------------------------------------------
module dec3to8 (
    input  logic [2:0] sel_i,
    input  logic       en_i,
    output logic [7:0] onehot_o
);

    assign onehot_o = en_i ? (8'b0000_0001 << sel_i) : 8'b0000_0000;

endmodule

// File: rtl/proc_control_unit.sv
// -----------------------------------------------------------------------------
// proc_control_unit
// Multi-cycle control sequencer for the 16-bit simple processor datapath
// (R0-R7, accumulator A, result G, add/sub ALU, shared bus). Holds the
// instruction register, decodes mv / mvi / add / sub and drives the per-cycle
// load enables and bus selects.
//   CLOCK    rising-edge clock
//   RESETN   asynchronous active-low reset
//   RUN      start request, sampled only in T0
//   DIN      data/instruction bus (instruction in T0, immediate in mvi T1)
//   IR_IN    IR load strobe
//   R_IN     one-hot register load enables (bit n = Rn)
//   R_OUT    one-hot bus select for Rn
//   DIN_OUT  bus select DIN
//   G_OUT    bus select G
//   A_IN     load A from bus
//   G_IN     load G from ALU
//   ADD      ALU function: 1 = add, 0 = subtract
//   BUSY     high while an instruction is past T0
//   DONE     one-cycle pulse in the final cycle of an instruction
// -----------------------------------------------------------------------------
module proc_control_unit
    import proc_control_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IR_WIDTH   = 9
) (
    input  logic                  CLOCK,
    input  logic                  RESETN,
    input  logic                  RUN,
    input  logic [DATA_WIDTH-1:0] DIN,
    output logic                  IR_IN,
    output logic [7:0]            R_IN,
    output logic [7:0]            R_OUT,
    output logic                  DIN_OUT,
    output logic                  G_OUT,
    output logic                  A_IN,
    output logic                  G_IN,
    output logic                  ADD,
    output logic                  BUSY,
    output logic                  DONE
);

    state_e              state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;

    logic [2:0] op;
    logic [7:0] x_onehot;
    logic [7:0] y_onehot;
    logic       busy;

    assign op   = ir_q[IR_OP_HI:IR_OP_LO];
    assign busy = (state_q != T0);

    // Only the low IR_WIDTH bits of DIN carry an instruction.
    if (DATA_WIDTH > IR_WIDTH) begin : g_din_upper
        logic unused_din_upper;
        assign unused_din_upper = ^DIN[DATA_WIDTH-1:IR_WIDTH];
    end

    // Register selects are only meaningful once an instruction is in flight;
    // the decoders sit idle in T0 where IR may still hold a stale value.
    dec3to8 u_dec_x (
        .sel_i    (ir_q[IR_X_HI:IR_X_LO]),
        .en_i     (busy),
        .onehot_o (x_onehot)
    );

    dec3to8 u_dec_y (
        .sel_i    (ir_q[IR_Y_HI:IR_Y_LO]),
        .en_i     (busy),
        .onehot_o (y_onehot)
    );

    // Next state and IR capture.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            T0: begin
                if (RUN) begin
                    ir_d    = DIN[IR_WIDTH-1:0];
                    state_d = T1;
                end
            end
            T1:      state_d = is_alu_op(op) ? T2 : T0;
            T2:      state_d = T3;
            T3:      state_d = T0;
            default: state_d = T0;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples its pre-edge value regardless of statement order.
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Control outputs, decoded from step, RUN and IR. Reset holds the
    // sequencer in T0, so only the RUN-driven IR strobe needs explicit gating
    // to keep every output low while RESETN is asserted.
    always_comb begin
        IR_IN   = 1'b0;
        R_IN    = 8'h00;
        R_OUT   = 8'h00;
        DIN_OUT = 1'b0;
        G_OUT   = 1'b0;
        A_IN    = 1'b0;
        G_IN    = 1'b0;
        ADD     = 1'b0;
        DONE    = 1'b0;
        unique case (state_q)
            T0: IR_IN = RUN & RESETN;
            T1: begin
                unique case (op)
                    OP_MV: begin
                        R_OUT = y_onehot;
                        R_IN  = x_onehot;
                        DONE  = 1'b1;
                    end
                    OP_MVI: begin
                        DIN_OUT = 1'b1;
                        R_IN    = x_onehot;
                        DONE    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        R_OUT = x_onehot;
                        A_IN  = 1'b1;
                    end
                    // Reserved opcodes complete immediately as a NOP.
                    default: DONE = 1'b1;
                endcase
            end
            T2: begin
                R_OUT = y_onehot;
                G_IN  = 1'b1;
                ADD   = (op == OP_ADD);
            end
            T3: begin
                G_OUT = 1'b1;
                R_IN  = x_onehot;
                DONE  = 1'b1;
            end
            default: ;
        endcase
    end

    assign BUSY = busy;

endmodule

// File: tb/tb_proc_control_unit.sv
// -----------------------------------------------------------------------------
// tb_proc_control_unit
// Self-checking bench for proc_control_unit. The reference model describes
// each instruction as a list of per-cycle control words (its micro-program);
// an accepted instruction appends its list to a queue, and each clock consumes
// one entry. An empty queue means the sequencer is idle.
// -----------------------------------------------------------------------------
module tb_proc_control_unit;

    logic        CLOCK;
    logic        RESETN;
    logic        RUN;
    logic [15:0] DIN;
    logic        IR_IN;
    logic [7:0]  R_IN;
    logic [7:0]  R_OUT;
    logic        DIN_OUT;
    logic        G_OUT;
    logic        A_IN;
    logic        G_IN;
    logic        ADD;
    logic        BUSY;
    logic        DONE;

    proc_control_unit #(
        .DATA_WIDTH (16),
        .IR_WIDTH   (9)
    ) dut (
        .CLOCK   (CLOCK),
        .RESETN  (RESETN),
        .RUN     (RUN),
        .DIN     (DIN),
        .IR_IN   (IR_IN),
        .R_IN    (R_IN),
        .R_OUT   (R_OUT),
        .DIN_OUT (DIN_OUT),
        .G_OUT   (G_OUT),
        .A_IN    (A_IN),
        .G_IN    (G_IN),
        .ADD     (ADD),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int total = 0;
    int bad   = 0;

    int accepted_cnt = 0;
    int done_cnt     = 0;

    // Expected control words still to be issued by the in-flight instruction.
    logic [23:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Control word layout: IR_IN, R_IN, R_OUT, DIN_OUT, G_OUT, A_IN, G_IN, ADD, BUSY, DONE.
    function automatic logic [23:0] word(input logic ir_in, input logic [7:0] r_in,
                                         input logic [7:0] r_out, input logic din_out,
                                         input logic g_out, input logic a_in,
                                         input logic g_in, input logic add,
                                         input logic busy, input logic done);
        return {ir_in, r_in, r_out, din_out, g_out, a_in, g_in, add, busy, done};
    endfunction

    function automatic logic [23:0] dut_word();
        return {IR_IN, R_IN, R_OUT, DIN_OUT, G_OUT, A_IN, G_IN, ADD, BUSY, DONE};
    endfunction

    function automatic logic [15:0] instr(input logic [2:0] op, input logic [2:0] x,
                                          input logic [2:0] y);
        return {7'd0, op, x, y};
    endfunction

    // Cycles an instruction spends after its fetch cycle.
    task automatic push_program(input logic [8:0] ir);
        logic [2:0] op;
        logic [7:0] ox;
        logic [7:0] oy;
        op = ir[8:6];
        ox = 8'h01 << ir[5:3];
        oy = 8'h01 << ir[2:0];
        case (op)
            3'd0: exp_q.push_back(word(0, ox, oy, 0, 0, 0, 0, 0, 1, 1));
            3'd1: exp_q.push_back(word(0, ox, 8'h00, 1, 0, 0, 0, 0, 1, 1));
            3'd2, 3'd3: begin
                // load A with Rx; G = A +/- Ry; Rx = G
                exp_q.push_back(word(0, 8'h00, ox, 0, 0, 1, 0, 0, 1, 0));
                exp_q.push_back(word(0, 8'h00, oy, 0, 0, 0, 1, op == 3'd2, 1, 0));
                exp_q.push_back(word(0, ox, 8'h00, 0, 1, 0, 0, 0, 1, 1));
            end
            default: exp_q.push_back(word(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1));
        endcase
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // against the model, then advance the model to what the rising edge does.
    task automatic cycle(input logic run, input logic [15:0] din, input string tag);
        logic [23:0] exp;
        @(negedge CLOCK);
        RUN = run;
        DIN = din;
        #1;
        if (exp_q.size() == 0) exp = word(run, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        else                   exp = exp_q[0];
        check(tag, {8'h00, dut_word()}, {8'h00, exp});
        if (DONE === 1'b1) done_cnt++;
        if (exp_q.size() == 0) begin
            if (run) begin
                accepted_cnt++;
                push_program(din[8:0]);
            end
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    int busy_cycles;

    initial begin
        RESETN = 1'b0;
        RUN    = 1'b0;
        DIN    = 16'h0000;
        #2;
        check("reset_outputs", {8'h00, dut_word()}, 32'h0);
        #20;
        @(negedge CLOCK);
        RESETN = 1'b1;
        cycle(0, 16'h0000, "idle");

        // mvi R0, #5
        cycle(1, 16'h0040, "mvi_t0");
        check("mvi_t0_irin", {31'd0, IR_IN}, 32'd1);
        cycle(0, 16'h0005, "mvi_t1");
        check("mvi_t1_dinout", {31'd0, DIN_OUT}, 32'd1);
        check("mvi_t1_rin", {24'd0, R_IN}, 32'h01);
        check("mvi_t1_done", {31'd0, DONE}, 32'd1);
        cycle(0, 16'h0000, "mvi_back_t0");
        check("mvi_back_busy", {31'd0, BUSY}, 32'd0);

        // mv R1, R0
        cycle(1, 16'h0008, "mv_t0");
        cycle(0, 16'hFFFF, "mv_t1");
        check("mv_t1_word", {8'h00, dut_word()},
              {8'h00, word(0, 8'h02, 8'h01, 0, 0, 0, 0, 0, 1, 1)});

        // add R2, R3
        busy_cycles = 0;
        cycle(1, 16'h0093, "add_t0");
        cycle(0, 16'h0000, "add_t1");
        if (BUSY) busy_cycles++;
        check("add_t1_rout", {24'd0, R_OUT}, 32'h04);
        check("add_t1_ain", {31'd0, A_IN}, 32'd1);
        cycle(0, 16'h0000, "add_t2");
        if (BUSY) busy_cycles++;
        check("add_t2_rout", {24'd0, R_OUT}, 32'h08);
        check("add_t2_gin_add", {30'd0, G_IN, ADD}, 32'd3);
        cycle(0, 16'h0000, "add_t3");
        if (BUSY) busy_cycles++;
        check("add_t3_word", {8'h00, dut_word()},
              {8'h00, word(0, 8'h04, 8'h00, 0, 1, 0, 0, 0, 1, 1)});
        cycle(0, 16'h0000, "add_after");
        if (BUSY) busy_cycles++;
        check("add_busy_cycles", busy_cycles, 32'd3);

        // sub R7, R7 then reserved opcode, RUN held high throughout
        cycle(1, 16'h00FF, "sub_t0");
        cycle(1, 16'h0100, "sub_t1");
        cycle(1, 16'h0100, "sub_t2");
        check("sub_t2_add", {31'd0, ADD}, 32'd0);
        check("sub_t2_rout", {24'd0, R_OUT}, 32'h80);
        cycle(1, 16'h0100, "sub_t3");
        check("sub_t3_done_rin", {23'd0, DONE, R_IN}, {23'd0, 1'b1, 8'h80});
        cycle(1, 16'h0100, "rsv_t0");
        check("rsv_t0_irin", {31'd0, IR_IN}, 32'd1);
        cycle(0, 16'h0000, "rsv_t1");
        check("rsv_t1_word", {8'h00, dut_word()},
              {8'h00, word(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1)});
        cycle(0, 16'h0000, "rsv_after");

        // Reset in the middle of add R5, R5: abort with RUN still high.
        cycle(1, instr(3'd2, 3'd5, 3'd5), "rst_add_t0");
        cycle(1, 16'h0000, "rst_add_t1");
        cycle(1, 16'h0000, "rst_add_t2");
        #2;
        RESETN = 1'b0;
        #1;
        check("rst_mid_outputs", {8'h00, dut_word()}, 32'h0);
        exp_q.delete();
        @(posedge CLOCK);
        #1;
        check("rst_hold_outputs", {8'h00, dut_word()}, 32'h0);
        @(negedge CLOCK);
        RUN    = 1'b0;
        RESETN = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) cycle(0, 16'h0093, "rst_release_idle");
        check("rst_no_done", done_cnt, 32'd0);

        // Random traffic over all opcodes and registers.
        accepted_cnt = 0;
        done_cnt     = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle(($urandom_range(0, 3) != 0), 16'($urandom), "rand");
            check("rand_bus_excl", {31'd0, ($countones({R_OUT, DIN_OUT, G_OUT}) <= 1)}, 32'd1);
            check("rand_add_gin", {31'd0, ADD & ~G_IN}, 32'd0);
        end
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) cycle(0, 16'h0000, "drain");
        check("drain_idle", exp_q.size(), 32'd0);
        check("done_vs_accepted", done_cnt, accepted_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
